mini_aes_mix_column: RTL



---
 rtl/mini_aes_pkg.sv | 60 ++++++
 rtl/mini_aes_mix_column_if.sv | 33 +++
 rtl/mini_aes_mix_column_req_rom.sv | 31 +++
 rtl/mini_aes_mix_column.sv | 115 +++++++++++
 4 files changed

// File: rtl/mini_aes_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mini_aes_pkg
// Brief    : Shared types and constants for the Mini-AES MixColumn stage.
// Revision : 1.0 - initial release
// ============================================================================
package mini_aes_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam int         STATE_W    = 16;
    localparam logic [3:0] MIX_C2     = 4'h2;
    localparam logic [3:0] MIX_C3     = 4'h3;
    localparam logic [1:0] NIB_0      = 2'd0;
    localparam logic [1:0] NIB_1      = 2'd1;
    localparam logic [1:0] NIB_2      = 2'd2;
    localparam logic [1:0] NIB_3      = 2'd3;
    localparam logic [4:0] GF_MODULUS = 5'b10011;

    // Nibble 0 is the most significant nibble of the state word.
    function automatic logic [3:0] get_nib(input logic [15:0] s, input logic [1:0] sel);
        logic [3:0] n;
        case (sel)
            NIB_0:   n = s[15:12];
            NIB_1:   n = s[11:8];
            NIB_2:   n = s[7:4];
            default: n = s[3:0];
        endcase
        return n;
    endfunction

    function automatic logic [15:0] place_nib(input logic [3:0] nib, input logic [1:0] sel);
        logic [15:0] w;
        w = '0;
        case (sel)
            NIB_0:   w[15:12] = nib;
            NIB_1:   w[11:8]  = nib;
            NIB_2:   w[7:4]   = nib;
            default: w[3:0]   = nib;
        endcase
        return w;
    endfunction

    function automatic logic [3:0] gf4_mul(input logic [3:0] a, input logic [3:0] b);
        logic [6:0] p;
        p = '0;
        for (int i = 0; i < 4; i++)
            if (b[i]) p = p ^ (7'(a) << i);
        for (int k = 6; k >= 4; k--)
            if (p[k]) p = p ^ (7'(GF_MODULUS) << (k - 4));
        return p[3:0];
    endfunction

endpackage
`default_nettype wire

// File: rtl/mini_aes_mix_column_if.sv
`default_nettype none
// ============================================================================
// Module   : mini_aes_mix_column_if
// Brief    : Stream and multiplier handshake bundle for the MixColumn stage.
// Revision : 1.0 - initial release
// ============================================================================
interface mini_aes_mix_column_if;
    import mini_aes_pkg::*;

    logic               in_valid;
    logic               in_ready;
    logic [STATE_W-1:0] state_in;
    logic               out_valid;
    logic               out_ready;
    logic [STATE_W-1:0] state_out;
    logic               err;
    logic               mul_start;
    logic [3:0]         mul_a;
    logic [3:0]         mul_b;
    logic               mul_done;
    logic [3:0]         mul_result;

    modport slave (
        input  in_valid, state_in, out_ready, mul_done, mul_result,
        output in_ready, out_valid, state_out, err, mul_start, mul_a, mul_b
    );

    modport master (
        output in_valid, state_in, out_ready, mul_done, mul_result,
        input  in_ready, out_valid, state_out, err, mul_start, mul_a, mul_b
    );
endinterface
`default_nettype wire

// File: rtl/mini_aes_mix_column_req_rom.sv
`default_nettype none
// ============================================================================
// Module   : mix_req_rom
// Brief    : Request index -> {source nibble, matrix coefficient, target nibble}.
// Revision : 1.0 - initial release
// ============================================================================
module mix_req_rom
    import mini_aes_pkg::*;
(
    input  logic [2:0] i_idx,
    output logic [1:0] o_src_sel,
    output logic [3:0] o_coef,
    output logic [1:0] o_dst_sel
);
    always_comb begin
        o_src_sel = NIB_0;
        o_coef    = MIX_C3;
        o_dst_sel = NIB_0;
        case (i_idx)
            3'd0: begin o_src_sel = NIB_0; o_coef = MIX_C3; o_dst_sel = NIB_0; end
            3'd1: begin o_src_sel = NIB_1; o_coef = MIX_C2; o_dst_sel = NIB_0; end
            3'd2: begin o_src_sel = NIB_0; o_coef = MIX_C2; o_dst_sel = NIB_1; end
            3'd3: begin o_src_sel = NIB_1; o_coef = MIX_C3; o_dst_sel = NIB_1; end
            3'd4: begin o_src_sel = NIB_2; o_coef = MIX_C3; o_dst_sel = NIB_2; end
            3'd5: begin o_src_sel = NIB_3; o_coef = MIX_C2; o_dst_sel = NIB_2; end
            3'd6: begin o_src_sel = NIB_2; o_coef = MIX_C2; o_dst_sel = NIB_3; end
            default: begin o_src_sel = NIB_3; o_coef = MIX_C3; o_dst_sel = NIB_3; end
        endcase
    end
endmodule
`default_nettype wire

// File: rtl/mini_aes_mix_column.sv
`default_nettype none
// ============================================================================
// Module   : mini_aes_mix_column
// Brief    : MixColumn via eight sequential GF(2^4) multiplier requests.
// Revision : 1.0 - initial release
// ============================================================================
module mini_aes_mix_column
    import mini_aes_pkg::*;
#(
    parameter int TIMEOUT = 64,
    parameter int NIB_W   = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    mini_aes_mix_column_if.slave bus
);
    localparam int                 c_cnt_w     = $clog2(TIMEOUT + 1);
    localparam logic [c_cnt_w-1:0] c_cnt_first = c_cnt_w'(1);
    localparam logic [c_cnt_w-1:0] c_cnt_last  = c_cnt_w'(TIMEOUT - 1);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [STATE_W-1:0] r_data;
    logic [STATE_W-1:0] r_acc;
    logic [2:0]         r_idx;
    logic [c_cnt_w-1:0] r_cnt;
    logic               r_err;

    logic [1:0]       w_src_sel;
    logic [1:0]       w_dst_sel;
    logic [NIB_W-1:0] w_coef;
    logic [NIB_W-1:0] w_src_nib;
    logic             w_accept;
    logic             w_take;
    logic             w_timeout;
    logic             w_req_active;

    mix_req_rom u_rom (
        .i_idx     (r_idx),
        .o_src_sel (w_src_sel),
        .o_coef    (w_coef),
        .o_dst_sel (w_dst_sel)
    );

    assign w_src_nib = get_nib(r_data, w_src_sel);

    always_ff @(posedge clk) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_take      = 1'b0;
        w_timeout   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus.in_valid) begin
                    w_accept    = 1'b1;
                    w_state_nxt = ST_ISSUE;
                end
            end
            ST_ISSUE: w_state_nxt = ST_WAIT;
            ST_WAIT: begin
                // A completion on the last allowed cycle still wins over the timeout.
                if (bus.mul_done) begin
                    w_take      = 1'b1;
                    w_state_nxt = (r_idx == 3'd7) ? ST_DONE : ST_ISSUE;
                end else if (r_cnt == c_cnt_last) begin
                    w_timeout   = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_DONE: begin
                if (bus.out_ready) w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    assign w_req_active  = (r_state == ST_ISSUE) || (r_state == ST_WAIT);
    assign bus.in_ready  = (r_state == ST_IDLE) && !rst;
    assign bus.out_valid = (r_state == ST_DONE);
    assign bus.state_out = (r_state == ST_DONE) ? r_acc : '0;
    assign bus.err       = r_err;
    assign bus.mul_start = (r_state == ST_ISSUE);
    assign bus.mul_a     = w_req_active ? w_src_nib : '0;
    assign bus.mul_b     = w_req_active ? w_coef : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_data <= '0;
            r_acc  <= '0;
            r_idx  <= '0;
            r_cnt  <= '0;
            r_err  <= 1'b0;
        end else begin
            if (w_accept) begin
                r_data <= bus.state_in;
                r_acc  <= '0;
                r_idx  <= '0;
            end
            // r_cnt tracks cycles elapsed since the mul_start pulse.
            if (r_state == ST_ISSUE)     r_cnt <= c_cnt_first;
            else if (r_state == ST_WAIT) r_cnt <= r_cnt + c_cnt_w'(1);
            if (w_take) begin
                r_acc <= r_acc ^ place_nib(bus.mul_result, w_dst_sel);
                r_idx <= r_idx + 3'd1;
            end
            if (w_timeout) r_err <= 1'b1;
        end
    end
endmodule
`default_nettype wire
